alu_seq: RTL and testbench

//  Registered, parametrised ALU for the multi-cycle/pipelined RISC-V datapath; replaces the combinational ALU.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_mul_iter.sv | 61 ++++++
 rtl/alu_seq.sv | 140 ++++++++++++++
 tb/tb_alu_seq.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Op codes and state encoding for the sequential ALU (alu_seq).
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_MUL   = 4'b1010;
  localparam logic [3:0] ALU_MULHU = 4'b1011;

  typedef enum logic {ST_IDLE, ST_MUL} alu_state_e;

  // True for the two multiplier op codes (only meaningful with ALU_MUL_EN).
  function automatic logic is_mul_op(logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULHU);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Handshake bus of the sequential ALU: input valid/ready with operands, output valid/ready
// with registered result and flags.
interface alu_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      op;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            carry;
  logic            overflow;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add unsigned multiplier, one multiplier bit per cycle for XLEN cycles.
// product is valid whenever done is high; it shows the final sum combinationally on the last
// iteration and then stays held until the next start.
module alu_mul_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] product
);
  localparam int unsigned CntW = $clog2(XLEN);

  logic [CntW-1:0]   cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic              busy_q;
  logic              fin_q;
  logic [2*XLEN-1:0] acc_step;
  logic              last;

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last     = busy_q && (cnt_q == CntW'(XLEN - 1));

  // Load operands on start, then add/shift once per cycle until the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      busy_q   <= 1'b0;
      fin_q    <= 1'b0;
    end else if (start) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{XLEN{1'b0}}, a};
      mplier_q <= b;
      busy_q   <= 1'b1;
      fin_q    <= 1'b0;
    end else if (busy_q) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (last) begin
        busy_q <= 1'b0;
        fin_q  <= 1'b1;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = last | fin_q;
  assign product = busy_q ? acc_step : acc_q;
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, result held until consumed.
// Optional iterative multiplier (MUL / MULHU) enabled by the ALU_MUL_EN macro.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            carry_q;
  logic            overflow_q;

  logic            slot_free;
  logic            accept;
  logic            mul_op;

  logic [XLEN-1:0] res_c;
  logic            carry_c;
  logic            ovf_c;
  logic [XLEN:0]   sum_ext;
  logic [XLEN-1:0] diff;
  logic [SHAMT_W-1:0] shamt;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && bus.in_ready;

`ifdef ALU_MUL_EN
  alu_state_e        state_q;
  logic              mul_hi_q;
  logic              mul_busy;
  logic              mul_done;
  logic [2*XLEN-1:0] mul_product;
  logic [XLEN-1:0]   mul_res;
  logic              mul_load;

  assign mul_op    = is_mul_op(bus.op);
  assign mul_res   = mul_hi_q ? mul_product[2*XLEN-1:XLEN] : mul_product[XLEN-1:0];
  assign mul_load  = (state_q == ST_MUL) && mul_done && slot_free;
  assign bus.in_ready = (state_q == ST_IDLE) && !mul_busy && slot_free;

  alu_mul_iter #(
    .XLEN (XLEN)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && mul_op),
    .a       (bus.a),
    .b       (bus.b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign mul_op       = 1'b0;
  assign bus.in_ready = slot_free;
`endif

  assign sum_ext = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff    = bus.a - bus.b;
  assign shamt   = bus.b[SHAMT_W-1:0];

  // Single-cycle op mux; unknown codes (and MUL codes when disabled) give 0.
  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (bus.op)
      ALU_AND: res_c = bus.a & bus.b;
      ALU_OR:  res_c = bus.a | bus.b;
      ALU_XOR: res_c = bus.a ^ bus.b;
      ALU_ADD: begin
        res_c   = sum_ext[XLEN-1:0];
        carry_c = sum_ext[XLEN];
        ovf_c   = (bus.a[XLEN-1] == bus.b[XLEN-1]) && (sum_ext[XLEN-1] != bus.a[XLEN-1]);
      end
      ALU_SUB: begin
        res_c   = diff;
        carry_c = bus.a < bus.b;
        ovf_c   = (bus.a[XLEN-1] != bus.b[XLEN-1]) && (diff[XLEN-1] != bus.a[XLEN-1]);
      end
      ALU_SLL:  res_c = bus.a << shamt;
      ALU_SRL:  res_c = bus.a >> shamt;
      ALU_SRA:  res_c = $unsigned($signed(bus.a) >>> shamt);
      ALU_SLT:  res_c = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      ALU_SLTU: res_c = {{(XLEN-1){1'b0}}, bus.a < bus.b};
      default:  res_c = '0;
    endcase
  end

  // Output register and control FSM; a fresh result may replace one being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef ALU_MUL_EN
      state_q     <= ST_IDLE;
      mul_hi_q    <= 1'b0;
`endif
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept && !mul_op) begin
        out_valid_q <= 1'b1;
        result_q    <= res_c;
        zero_q      <= (res_c == '0);
        carry_q     <= carry_c;
        overflow_q  <= ovf_c;
      end
`ifdef ALU_MUL_EN
      else if (accept) begin
        state_q  <= ST_MUL;
        mul_hi_q <= (bus.op == ALU_MULHU);
      end else if (mul_load) begin
        state_q     <= ST_IDLE;
        out_valid_q <= 1'b1;
        result_q    <= mul_res;
        zero_q      <= (mul_res == '0);
        carry_q     <= 1'b0;
        overflow_q  <= 1'b0;
      end
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model results at accept, monitor pops at
// output transfer. Build with +define+ALU_MUL_EN to cover the multiplier.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned XLEN = 32;
`ifdef ALU_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        carry;
    logic        overflow;
    int          lat;
    int          acc_edge;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.XLEN(XLEN)) bus ();

  alu_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   rdy_mode = 0;     // 0: always ready, 1: random, 2: stalled
  bit   lat_chk = 1'b1;   // multi-cycle latency is exact only with a free output slot
  bit   fresh = 1'b1;
  bit   hold_pending = 1'b0;
  logic [31:0] held_res;
  logic [2:0]  held_flags;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer side: out_ready changes just after the clock edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    exp_t        e;
    longint      s;
    logic [63:0] u;
    e.result = 0; e.carry = 0; e.overflow = 0; e.lat = 1; e.acc_edge = 0;
    case (op)
      ALU_AND: e.result = a & b;
      ALU_OR:  e.result = a | b;
      ALU_XOR: e.result = a ^ b;
      ALU_ADD: begin
        u = {32'd0, a} + {32'd0, b};
        e.result = u[31:0];
        e.carry = u[32];
        s = longint'($signed(a)) + longint'($signed(b));
        e.overflow = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_SUB: begin
        e.result = a - b;
        e.carry = (a < b);
        s = longint'($signed(a)) - longint'($signed(b));
        e.overflow = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_SLL:  e.result = a << (b % 32);
      ALU_SRL:  e.result = a >> (b % 32);
      ALU_SRA:  e.result = $signed(a) >>> (b % 32);
      ALU_SLT:  e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: e.result = (a < b) ? 32'd1 : 32'd0;
      ALU_MUL, ALU_MULHU: begin
        if (MulEn) begin
          u = {32'd0, a} * {32'd0, b};
          e.result = (op == ALU_MUL) ? u[31:0] : u[63:32];
          e.lat = XLEN + 1;
        end
      end
      default: e.result = 0;
    endcase
    e.zero = (e.result == 0);
    return e;
  endfunction

  // Present one op (call just after a posedge); returns just after its accept edge.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] iop);
    exp_t e;
    bit   ok = 1'b0;
    bus.in_valid = 1'b1; bus.a = ia; bus.b = ib; bus.op = iop;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL accept_timeout op=%b: in_ready stayed 0, required 1", iop);
    end else begin
      e = model(ia, ib, iop);
      e.acc_edge = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    // Scramble inputs after accept: the DUT must have latched them.
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.op = 4'($urandom);
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: checks latency, hold stability, back-pressure and the transferred result.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: result=%h with empty scoreboard", bus.result);
      end else begin
        if (fresh && (sb[0].lat == 1 || lat_chk)) begin
          vectors++;
          if (cyc - sb[0].acc_edge != sb[0].lat - 1) begin
            miscompares++;
            $display("FAIL latency: %0d edges, required %0d", cyc - sb[0].acc_edge + 1,
                     sb[0].lat);
          end
        end
        if (hold_pending) begin
          vectors++;
          if (bus.result !== held_res ||
              {bus.zero, bus.carry, bus.overflow} !== held_flags) begin
            miscompares++;
            $display("FAIL hold_stable: result=%h flags=%b, required %h %b", bus.result,
                     {bus.zero, bus.carry, bus.overflow}, held_res, held_flags);
          end
        end
        if (bus.out_ready) begin
          vectors++;
          if (bus.result !== sb[0].result || bus.zero !== sb[0].zero ||
              bus.carry !== sb[0].carry || bus.overflow !== sb[0].overflow) begin
            miscompares++;
            $display("FAIL result: got %h z%b c%b v%b, required %h z%b c%b v%b", bus.result,
                     bus.zero, bus.carry, bus.overflow, sb[0].result, sb[0].zero,
                     sb[0].carry, sb[0].overflow);
          end
          void'(sb.pop_front());
          fresh = 1'b1;
          hold_pending = 1'b0;
        end else begin
          vectors++;
          if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure: in_ready=%b, required 0", bus.in_ready);
          end
          fresh = 1'b0;
          hold_pending = 1'b1;
          held_res = bus.result;
          held_flags = {bus.zero, bus.carry, bus.overflow};
        end
      end
    end
  end

  initial begin
    int bad;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.zero !== 1'b0 ||
        bus.carry !== 1'b0 || bus.overflow !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: v%b r=%h z%b c%b o%b rdy%b, required v0 r=0 z0 c0 o0 rdy1",
               bus.out_valid, bus.result, bus.zero, bus.carry, bus.overflow, bus.in_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed corners.
    issue(32'hFFFF_FFFF, 32'h1, ALU_ADD);
    issue(32'h8000_0000, 32'h1, ALU_SUB);
    issue(32'h5, 32'h5, ALU_SUB);
    issue(32'h8000_0000, 32'd36, ALU_SRA);
    issue(32'h1, 32'd33, ALU_SLL);
    issue(32'hFFFF_FFFF, 32'h0, ALU_SLT);
    issue(32'hFFFF_FFFF, 32'h0, ALU_SLTU);
    issue(32'h1234_5678, 32'h9, 4'b1100);
    issue(32'h7FFF_FFFF, 32'h1, ALU_ADD);

    // Ten back-to-back adds.
    for (int i = 0; i < 10; i++) issue($urandom, $urandom, ALU_ADD);
    wait_drain();

    // Stall the output for three cycles while another op waits at the input.
    rdy_mode = 2;
    issue(32'hDEAD_0000, 32'h0000_BEEF, ALU_OR);
    fork
      issue(32'hF0F0_F0F0, 32'hFFFF_0000, ALU_XOR);
      begin
        repeat (3) @(posedge clk);
        rdy_mode = 0;
      end
    join
    wait_drain();

    if (MulEn) begin
      issue(32'h0000_FFFF, 32'h0000_FFFF, ALU_MUL);
      bad = 0;
      for (int n = 0; n < 100 && !bus.out_valid; n++) begin
        if (bus.in_ready) bad++;
        @(negedge clk);
      end
      vectors++;
      if (bad != 0 || !bus.out_valid) begin
        miscompares++;
        $display("FAIL mul_busy: in_ready high %0d cycles (out_valid=%b), required 0 (1)",
                 bad, bus.out_valid);
      end
      @(posedge clk);
      #1;
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_MULHU);
      wait_drain();
    end

    // Randomized traffic with random back-pressure.
    rdy_mode = 1;
    lat_chk = 1'b0;
    for (int i = 0; i < 300; i++) begin
      issue(pick_operand(), pick_operand(), 4'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain();
    rdy_mode = 0;
    lat_chk = 1'b1;

    // Reset in the middle of an operation (a multiply when enabled).
    issue(32'h0001_2345, 32'h0000_0777, MulEn ? ALU_MUL : ALU_ADD);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    fresh = 1'b1;
    hold_pending = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort_valid: out_valid=%b, required 0", bus.out_valid);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (MulEn ? 40 : 2) @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_recover: in_ready=%b out_valid=%b, required 1 0", bus.in_ready,
               bus.out_valid);
    end
    @(posedge clk);
    #1;
    issue(32'd2, 32'd3, ALU_ADD);
    issue(32'hCAFE_0001, 32'h0000_0003, ALU_MUL);
    wait_drain();

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: %0d left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
